// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader and the control decoder.
// Holds the 3-bit op-class codes, the 6-bit MIPS primary opcodes they map to,
// and the loader state encoding.
package instr_encode_loader_pkg;

  // Op classes carried on the command bus (7 is reserved/illegal)
  localparam logic [2:0] OP_R_TYPE = 3'd0;
  localparam logic [2:0] OP_ADDI   = 3'd1;
  localparam logic [2:0] OP_SLTIU  = 3'd2;
  localparam logic [2:0] OP_BEQ    = 3'd3;
  localparam logic [2:0] OP_LUI    = 3'd4;
  localparam logic [2:0] OP_ORI    = 3'd5;
  localparam logic [2:0] OP_BNE    = 3'd6;

  // MIPS primary opcodes
  localparam logic [5:0] OPC_R_TYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_SLTIU  = 6'b001011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_LUI    = 6'b001111;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_BNE    = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Command and memory-write bus of the program loader.
//   cmd_*  : symbolic instruction command, valid/ready handshake (host -> loader)
//   mem_*  : instruction-memory write port with back-pressure (loader -> memory)
// modport master : host / memory side
// modport slave  : the loader
interface instr_encode_loader_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [4:0]  cmd_rs_i;
  logic [4:0]  cmd_rt_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_shamt_i;
  logic [5:0]  cmd_funct_i;
  logic [15:0] cmd_imm_i;
  logic        cmd_last_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_rs_i, cmd_rt_i, cmd_rd_i, cmd_shamt_i,
           cmd_funct_i, cmd_imm_i, cmd_last_i, mem_ready_i,
    input  cmd_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_rs_i, cmd_rt_i, cmd_rd_i, cmd_shamt_i,
           cmd_funct_i, cmd_imm_i, cmd_last_i, mem_ready_i,
    output cmd_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational encoder: op class plus register/immediate fields -> 32-bit MIPS word.
//   op_i            : op class
//   rs_i..funct_i   : R-type fields
//   imm_i           : I-type immediate / branch offset
//   word_o          : encoded instruction (0 when illegal)
//   illegal_o       : op class has no encoding
module instr_field_packer
  import instr_encode_loader_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Field packing per op class; LUI has no source register so rs is forced to 0
  always_comb begin
    word_o    = 32'h0000_0000;
    illegal_o = 1'b0;
    case (op_i)
      OP_R_TYPE: word_o = {OPC_R_TYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      OP_ADDI:   word_o = {OPC_ADDI,  rs_i, rt_i, imm_i};
      OP_SLTIU:  word_o = {OPC_SLTIU, rs_i, rt_i, imm_i};
      OP_BEQ:    word_o = {OPC_BEQ,   rs_i, rt_i, imm_i};
      OP_LUI:    word_o = {OPC_LUI,   5'd0, rt_i, imm_i};
      OP_ORI:    word_o = {OPC_ORI,   rs_i, rt_i, imm_i};
      OP_BNE:    word_o = {OPC_BNE,   rs_i, rt_i, imm_i};
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts symbolic commands, encodes them and writes them
// sequentially into instruction memory starting at BASE_ADDR.
//   clk_i, rst_i (sync, active-low), start_i (begin program, IDLE only)
//   bus      : command handshake + memory write port (slave side)
//   busy_o   : not IDLE
//   done_o   : one-cycle pulse at program end
//   err_o    : sticky; illegal op or program overflow
//   count_o  : words written in the current program
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  instr_encode_loader_if.slave bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CW-1:0]        count_o
);

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  state_t        state_r, state_s;
  logic          mem_we_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_data_r;
  logic [31:0]   next_addr_r;
  logic [CW-1:0] count_r;
  logic          err_r;

  logic [31:0]   packed_word_s;
  logic          illegal_s;
  logic          complete_s;
  logic          cmd_ready_s;
  logic          accept_s;
  logic          overflow_s;
  logic [CW:0]   occupancy_s;

  instr_field_packer u_packer (
    .op_i      (bus.cmd_op_i),
    .rs_i      (bus.cmd_rs_i),
    .rt_i      (bus.cmd_rt_i),
    .rd_i      (bus.cmd_rd_i),
    .shamt_i   (bus.cmd_shamt_i),
    .funct_i   (bus.cmd_funct_i),
    .imm_i     (bus.cmd_imm_i),
    .word_o    (packed_word_s),
    .illegal_o (illegal_s)
  );

  // Words written plus the one held in the output register
  assign occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, mem_we_r};
  assign complete_s  = mem_we_r & bus.mem_ready_i;
  assign cmd_ready_s = (state_r == ST_RUN) && (!mem_we_r || bus.mem_ready_i) &&
                       (occupancy_s < DEPTH_W);
  assign accept_s    = cmd_ready_s & bus.cmd_valid_i;
  // An accepted command can only be taken while any pending write completes on
  // the same edge, so afterwards occupancy is the current value plus one.
  assign overflow_s  = accept_s && !illegal_s && !bus.cmd_last_i &&
                       ((occupancy_s + (CW + 1)'(1)) == DEPTH_W);

  assign bus.cmd_ready_o = cmd_ready_s;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_data_o  = mem_data_r;
  assign busy_o          = (state_r != ST_IDLE);
  assign done_o          = (state_r == ST_DONE);
  assign err_o           = err_r;
  assign count_o         = count_r;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_s = ST_RUN;
        else         state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && (bus.cmd_last_i || overflow_s)) state_s = ST_DRAIN;
        else                                            state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!mem_we_r || bus.mem_ready_i) state_s = ST_DONE;
        else                              state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Program bookkeeping: word count, next write address and sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_r     <= {CW{1'b0}};
      next_addr_r <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else if (state_r == ST_IDLE && start_i) begin
      count_r     <= {CW{1'b0}};
      next_addr_r <= BASE_ADDR;
      err_r       <= 1'b0;
    end else begin
      if (complete_s) begin
        count_r     <= count_r + CW'(1);
        next_addr_r <= next_addr_r + 32'd4;
      end
      if (accept_s && (illegal_s || overflow_s)) err_r <= 1'b1;
    end
  end

  // Write output register; a new word reloads it on the completing edge so
  // back-to-back writes need no bubble
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_we_r   <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      mem_data_r <= 32'h0000_0000;
    end else if (accept_s && !illegal_s) begin
      mem_we_r   <= 1'b1;
      mem_addr_r <= complete_s ? (next_addr_r + 32'd4) : next_addr_r;
      mem_data_r <= packed_word_s;
    end else if (complete_s) begin
      mem_we_r   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader. Instance a uses DEPTH=256,
// instance b uses DEPTH=2 for the overflow case.
module tb_instr_encode_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [8:0] count_a;
  logic [1:0] count_b;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  cyc = 0;
  int  idx_a = 0;
  int  idx_b = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t log_a[$];
  wr_t log_b[$];
  wr_t w_m;

  instr_encode_loader_if bus_a();
  instr_encode_loader_if bus_b();

  instr_encode_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .bus(bus_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .count_o(count_a)
  );

  instr_encode_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .bus(bus_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .count_o(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %08h required %08h", name, act, exp);
  endtask

  // Reference encoding from the instruction-format definitions
  function automatic logic [31:0] model_word(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm);
    longint opc_tab [0:6];
    longint w;
    opc_tab = '{0, 8, 11, 4, 15, 13, 5};
    if (op == 0) w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
    else begin
      if (op == 4) rs = 0;
      w = opc_tab[op] * 67108864 + rs * 2097152 + rt * 65536 + imm;
    end
    return w[31:0];
  endfunction

  // Compare process: whenever a write is presented it must match the oldest
  // outstanding expected word; completed writes are logged.
  always @(negedge clk) begin
    if (bus_a.mem_we_o === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_write", 32'd1, 32'd0);
      else begin
        chk("a_addr", bus_a.mem_addr_o, exp_a[0].addr);
        chk("a_data", bus_a.mem_data_o, exp_a[0].data);
        if (bus_a.mem_ready_i === 1'b1) begin
          w_m.addr = bus_a.mem_addr_o; w_m.data = bus_a.mem_data_o; w_m.cyc = cyc;
          log_a.push_back(w_m);
          void'(exp_a.pop_front());
        end
      end
    end
    if (bus_b.mem_we_o === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_write", 32'd1, 32'd0);
      else begin
        chk("b_addr", bus_b.mem_addr_o, exp_b[0].addr);
        chk("b_data", bus_b.mem_data_o, exp_b[0].data);
        if (bus_b.mem_ready_i === 1'b1) begin
          w_m.addr = bus_b.mem_addr_o; w_m.data = bus_b.mem_data_o; w_m.cyc = cyc;
          log_b.push_back(w_m);
          void'(exp_b.pop_front());
        end
      end
    end
  end

  // All tasks below start and end at posedge+1
  task automatic do_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    if (sel) idx_b = 0; else idx_a = 0;
  endtask

  task automatic send(input bit sel, input int op, input int rs, input int rt, input int rd,
                      input int sh, input int fn, input int imm, input bit last,
                      input int budget, input bit exp_acc);
    bit  acc;
    wr_t w;
    if (sel) begin
      bus_b.cmd_op_i = 3'(op); bus_b.cmd_rs_i = 5'(rs); bus_b.cmd_rt_i = 5'(rt);
      bus_b.cmd_rd_i = 5'(rd); bus_b.cmd_shamt_i = 5'(sh); bus_b.cmd_funct_i = 6'(fn);
      bus_b.cmd_imm_i = 16'(imm); bus_b.cmd_last_i = last; bus_b.cmd_valid_i = 1'b1;
    end else begin
      bus_a.cmd_op_i = 3'(op); bus_a.cmd_rs_i = 5'(rs); bus_a.cmd_rt_i = 5'(rt);
      bus_a.cmd_rd_i = 5'(rd); bus_a.cmd_shamt_i = 5'(sh); bus_a.cmd_funct_i = 6'(fn);
      bus_a.cmd_imm_i = 16'(imm); bus_a.cmd_last_i = last; bus_a.cmd_valid_i = 1'b1;
    end
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      acc = sel ? (bus_b.cmd_ready_o === 1'b1) : (bus_a.cmd_ready_o === 1'b1);
      @(posedge clk); #1;
    end
    bus_a.cmd_valid_i = 1'b0; bus_b.cmd_valid_i = 1'b0;
    chk(sel ? "b_accept" : "a_accept", {31'd0, acc}, {31'd0, exp_acc});
    if (acc && op != 7) begin
      w.addr = 32'(4 * (sel ? idx_b : idx_a));
      w.data = model_word(op, rs, rt, rd, sh, fn, imm);
      w.cyc  = 0;
      if (sel) begin exp_b.push_back(w); idx_b++; end
      else     begin exp_a.push_back(w); idx_a++; end
    end
  endtask

  task automatic wait_done(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? (done_b === 1'b1) : (done_a === 1'b1);
      if (!seen) begin @(posedge clk); #1; end
    end
    chk(sel ? "b_done_pulse" : "a_done_pulse", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk(sel ? "b_done_width" : "a_done_width", {31'd0, sel ? done_b : done_a}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_we"},    {31'd0, bus_a.mem_we_o},    32'd0);
    chk({tag, "_addr"},  bus_a.mem_addr_o,           32'd0);
    chk({tag, "_data"},  bus_a.mem_data_o,           32'd0);
    chk({tag, "_ready"}, {31'd0, bus_a.cmd_ready_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_a},            32'd0);
    chk({tag, "_done"},  {31'd0, done_a},            32'd0);
    chk({tag, "_err"},   {31'd0, err_a},             32'd0);
    chk({tag, "_count"}, {23'd0, count_a},           32'd0);
  endtask

  initial begin
    bus_a.cmd_valid_i = 1'b0; bus_a.cmd_op_i = 3'd0; bus_a.cmd_rs_i = 5'd0;
    bus_a.cmd_rt_i = 5'd0; bus_a.cmd_rd_i = 5'd0; bus_a.cmd_shamt_i = 5'd0;
    bus_a.cmd_funct_i = 6'd0; bus_a.cmd_imm_i = 16'd0; bus_a.cmd_last_i = 1'b0;
    bus_a.mem_ready_i = 1'b1;
    bus_b.cmd_valid_i = 1'b0; bus_b.cmd_op_i = 3'd0; bus_b.cmd_rs_i = 5'd0;
    bus_b.cmd_rt_i = 5'd0; bus_b.cmd_rd_i = 5'd0; bus_b.cmd_shamt_i = 5'd0;
    bus_b.cmd_funct_i = 6'd0; bus_b.cmd_imm_i = 16'd0; bus_b.cmd_last_i = 1'b0;
    bus_b.mem_ready_i = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk_reset_a("rst0");
    chk("rst0_b_busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single ADDI, last
    do_start(1'b0);
    send(1'b0, 1, 1, 2, 0, 0, 0, 16'h0005, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t1_count", {23'd0, count_a}, 32'd1);
    chk("t1_err", {31'd0, err_a}, 32'd0);
    chk("t1_nwr", log_a.size(), 32'd1);
    chk("t1_addr", log_a[0].addr, 32'h0000_0000);
    chk("t1_data", log_a[0].data, 32'h2022_0005);
    @(posedge clk); #1;

    // R_TYPE then LUI, back to back
    log_a.delete();
    do_start(1'b0);
    send(1'b0, 0, 1, 2, 3, 0, 6'h20, 0, 1'b0, 10, 1'b1);
    send(1'b0, 4, 7, 4, 0, 0, 0, 16'h1234, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t2_count", {23'd0, count_a}, 32'd2);
    chk("t2_nwr", log_a.size(), 32'd2);
    chk("t2_d0", log_a[0].data, 32'h0022_1820);
    chk("t2_a0", log_a[0].addr, 32'h0000_0000);
    chk("t2_d1", log_a[1].data, 32'h3C04_1234);
    chk("t2_a1", log_a[1].addr, 32'h0000_0004);
    chk("t2_b2b", 32'(log_a[1].cyc - log_a[0].cyc), 32'd1);
    @(posedge clk); #1;

    // BNE under back-pressure, then ADDI last
    log_a.delete();
    do_start(1'b0);
    bus_a.mem_ready_i = 1'b0;
    send(1'b0, 6, 1, 0, 0, 0, 0, 16'hFFFE, 1'b0, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", {31'd0, bus_a.cmd_ready_o}, 32'd0);
      chk("t3_stall_we", {31'd0, bus_a.mem_we_o}, 32'd1);
      chk("t3_stall_data", bus_a.mem_data_o, 32'h1420_FFFE);
      @(posedge clk); #1;
    end
    bus_a.mem_ready_i = 1'b1;
    send(1'b0, 1, 3, 4, 0, 0, 0, 16'h0007, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t3_count", {23'd0, count_a}, 32'd2);
    chk("t3_a1", log_a[1].addr, 32'h0000_0004);
    chk("t3_d1", log_a[1].data, 32'h2064_0007);
    @(posedge clk); #1;

    // Illegal op between two ADDIs
    log_a.delete();
    do_start(1'b0);
    send(1'b0, 1, 1, 2, 0, 0, 0, 16'h0005, 1'b0, 10, 1'b1);
    send(1'b0, 7, 0, 0, 0, 0, 0, 0, 1'b0, 10, 1'b1);
    send(1'b0, 1, 3, 4, 0, 0, 0, 16'h0007, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t4_nwr", log_a.size(), 32'd2);
    chk("t4_a1", log_a[1].addr, 32'h0000_0004);
    chk("t4_count", {23'd0, count_a}, 32'd2);
    chk("t4_err", {31'd0, err_a}, 32'd1);
    @(posedge clk); #1;
    do_start(1'b0);
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err_a}, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 1, 1, 2, 0, 0, 0, 16'h0005, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t4_err_after", {31'd0, err_a}, 32'd0);
    @(posedge clk); #1;

    // DEPTH=2 overflow, no last
    do_start(1'b1);
    send(1'b1, 1, 1, 2, 0, 0, 0, 16'h0005, 1'b0, 10, 1'b1);
    send(1'b1, 1, 3, 4, 0, 0, 0, 16'h0007, 1'b0, 10, 1'b1);
    wait_done(1'b1);
    send(1'b1, 1, 5, 6, 0, 0, 0, 16'h0009, 1'b0, 5, 1'b0);
    @(negedge clk);
    chk("t5_err", {31'd0, err_b}, 32'd1);
    chk("t5_count", {30'd0, count_b}, 32'd2);
    chk("t5_nwr", log_b.size(), 32'd2);
    chk("t5_a1", log_b[1].addr, 32'h0000_0004);
    @(posedge clk); #1;

    // Reset with a write pending, then restart
    log_a.delete();
    do_start(1'b0);
    bus_a.mem_ready_i = 1'b0;
    send(1'b0, 1, 1, 2, 0, 0, 0, 16'h0005, 1'b0, 10, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_a.delete();
    @(negedge clk);
    chk_reset_a("rst1");
    @(posedge clk); #1;
    rst = 1'b1;
    bus_a.mem_ready_i = 1'b1;
    do_start(1'b0);
    send(1'b0, 1, 3, 4, 0, 0, 0, 16'h0007, 1'b1, 10, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    chk("t6_nwr", log_a.size(), 32'd1);
    chk("t6_addr", log_a[0].addr, 32'h0000_0000);
    chk("t6_data", log_a[0].data, 32'h2064_0007);
    chk("t6_count", {23'd0, count_a}, 32'd1);
    chk("end_pending_a", exp_a.size(), 32'd0);
    chk("end_pending_b", exp_b.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Program-loader front end for the single-cycle CPU. It accepts symbolic instruction commands (op class, register fields, immediate) over a valid/ready handshake.
- Each command is encoded into a 32-bit MIPS word and written sequentially into instruction memory through a write port with back-pressure.
- It is the encoding counterpart of the control decoder: it produces opcode/field bit patterns from the same 3-bit op-class set.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 256, maximum words per program; must be ≥1.
- CW, $clog2(DEPTH+1), width of count_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  pulse; starts a new program at BASE_ADDR; honoured only in IDLE.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_op_i  in  3  op class: 0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE; 7 is illegal.
- cmd_rs_i / cmd_rt_i / cmd_rd_i / cmd_shamt_i  in  5 each  register and shamt fields.
- cmd_funct_i  in  6  R-type funct.
- cmd_imm_i  in  16  immediate / branch offset.
- cmd_last_i  in  1  marks the final command of a program.
- mem_we_o  out  1  write request; held until mem_ready_i.
- mem_addr_o  out  32  byte address.
- mem_data_o  out  32  encoded word.
- mem_ready_i  in  1  memory accepts the write this cycle.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at program end.
- err_o  out  1  sticky error; cleared by an accepted start_i or by reset.
- count_o  out  CW  words written so far.

Behaviour:
- Reset (rst_i=0 at a clk_i edge):
  - State goes to IDLE.
  - All outputs are 0: cmd_ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o, count_o.
  - A write in progress is abandoned; mem_we_o is low the cycle after reset.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start_i, go to RUN; clear count_o and err_o; set the next address to BASE_ADDR.
  - RUN: accept commands.
  - DRAIN: wait until mem_we_o is low, or until mem_we_o&mem_ready_i completes the pending write; then go to DONE.
  - DONE: assert done_o for one cycle, then go to IDLE.
  - start_i outside IDLE is ignored.
- cmd_ready_o = (state==RUN) && (!mem_we_o || mem_ready_i) && (count_o + pending < DEPTH). "pending" is 1 while mem_we_o is high.
- Latency: a command accepted at edge N appears as mem_we_o=1 with stable addr/data from edge N+1. Back-to-back accepts are allowed when mem_ready_i=1 every cycle, giving one word per cycle.
- Write completion: mem_we_o&mem_ready_i at an edge. On completion, count_o increments and the next address advances by 4. A new command accepted on the same edge loads the output register directly, so mem_we_o stays high with no bubble.
- Encoding:
  - R_TYPE: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {opc, rs, rt, imm}, with opc ADDI 001000, SLTIU 001011, BEQ 000100, LUI 001111, ORI 001101, BNE 000101.
  - LUI forces rs=0.
  - Unused fields are ignored.
- Illegal op 7: the command is accepted (handshake completes), nothing is written, and err_o is set.
- Termination: an accepted command with cmd_last_i=1 (legal or illegal) moves RUN→DRAIN.
- Overflow: if count_o+pending reaches DEPTH and the last accepted command had cmd_last_i=0, err_o is set and the state moves RUN→DRAIN. Filling exactly DEPTH with cmd_last_i=1 is not an error.
- Address: mem_addr_o = BASE_ADDR + 4*count_o at load time; the 32-bit add wraps silently.

Decomposition:
- Shared package (with the decoder): the op-class localparams R_TYPE..BNE, the 6-bit opcode constants, and the state encoding.
- One combinational sub-module, instr_field_packer: maps op class plus fields to a 32-bit word and an illegal flag.
- The FSM, output register and counter stay in the top level.

Test Plan:
- start; ADDI rs=1 rt=2 imm=0x0005, last=1, mem_ready_i=1 → one write of 0x20220005 at addr 0x0; done_o pulses; count_o=1; err_o=0.
- R_TYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20, then LUI rs=7 rt=4 imm=0x1234 (last) → 0x00221820 @0x0, 0x3C041234 @0x4, with back-to-back mem_we_o.
- BNE rs=1 rt=0 imm=0xFFFE with mem_ready_i low for 3 cycles → mem_we_o, addr and data (0x1420FFFE) held stable; cmd_ready_o=0 until the write completes.
- op=7 mid-stream between two ADDIs → only 2 writes (addr 0x0, 0x4); err_o=1 sticky; the next start_i clears it.
- DEPTH=2; three commands, none last → two writes; the third is not accepted; err_o=1; done_o pulses.
- rst_i low while mem_we_o=1 → the next cycle shows all outputs 0 and state IDLE; start_i then restarts at BASE_ADDR.
